// File: rtl/bip_pkg.sv
// Shared types and constants for the BIP fetch path.
//   AB_W   : default program-counter address width
//   OPW    : opcode width (opcode = instr[IW-1 -: OPW])
//   HLT_OP : opcode of the HLT instruction
//   state_t: fetch sequencer state
//   tag_t  : one in-flight fetch marker {valid, addr}
package bip_pkg;
  localparam int unsigned AB_W = 11;
  localparam int unsigned OPW  = 5;
  localparam logic [OPW-1:0] HLT_OP = 5'b00000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } state_t;

  typedef struct packed {
    logic            valid;
    logic [AB_W-1:0] addr;
  } tag_t;
endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Bundle between the control unit / Program Counter / program memory and
// the fetch sequencer.
//   slave  : the sequencer side (drives wr_pc, address_bus, instr_* out, halted, busy)
//   master : the surrounding system side
interface pc_fetch_sequencer_if
  import bip_pkg::*;
#(
  parameter int unsigned AB = AB_W,
  parameter int unsigned IW = 16
);
  logic          start;
  logic          jump_en;
  logic [AB-1:0] jump_addr;
  logic          wr_pc;
  logic [AB-1:0] address_bus;
  logic [IW-1:0] instr_in;
  logic [IW-1:0] instr_out;
  logic [AB-1:0] instr_pc;
  logic          instr_valid;
  logic          instr_ready;
  logic          halted;
  logic          busy;

  modport slave (
    input  start, jump_en, jump_addr, instr_in, instr_ready,
    output wr_pc, address_bus, instr_out, instr_pc, instr_valid, halted, busy
  );

  modport master (
    output start, jump_en, jump_addr, instr_in, instr_ready,
    input  wr_pc, address_bus, instr_out, instr_pc, instr_valid, halted, busy
  );
endinterface

// File: rtl/fetch_tag_pipe.sv
// Two-stage shift register of {valid, addr} tags that follows each issued
// address through the Program Counter and the synchronous memory, so that
// stage2 lines up with the matching instr_in word.
//   clk, rst_n : clock, async active-low reset
//   push       : a fetch is issued this cycle
//   addr       : address of that fetch
//   flush      : drop everything in flight (including this cycle's push)
//   stage2     : tag aligned with instr_in
module fetch_tag_pipe
  import bip_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic [AB_W-1:0] addr,
  input  logic            flush,
  output tag_t            stage2
);
  tag_t stage1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage1 <= '0;
      stage2 <= '0;
    end else if (flush) begin
      stage1 <= '0;
      stage2 <= '0;
    end else begin
      stage1 <= '{valid: push, addr: addr};
      stage2 <= stage1;
    end
  end
endmodule

// File: rtl/pc_fetch_sequencer.sv
// Fetch sequencer: issues one sequential fetch per RUN cycle to the Program
// Counter, tracks in-flight fetches, presents instructions on a valid/ready
// handshake and handles jumps, back-pressure replay and HLT.
//   clk, rst_n : clock, async active-low reset
//   bus        : start/jump_en/jump_addr/instr_in/instr_ready in;
//                wr_pc/address_bus/instr_out/instr_pc/instr_valid/halted/busy out
module pc_fetch_sequencer
  import bip_pkg::*;
#(
  parameter int unsigned AB  = AB_W,
  parameter int unsigned IW  = 16,
  parameter int unsigned OPW = bip_pkg::OPW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pc_fetch_sequencer_if.slave  bus
);
  state_t        state;
  state_t        state_nxt;
  logic [AB-1:0] fetch_addr;
  tag_t          s2;
  logic          run;
  logic          start_run;
  logic          load;
  logic          replay;
  logic          hlt_load;
  logic          flush;

  fetch_tag_pipe u_tag_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (run),
    .addr   (AB_W'(fetch_addr)),
    .flush  (flush),
    .stage2 (s2)
  );

  always_comb begin
    run       = (state == RUN);
    start_run = bus.start && !run;
    load      = run && s2.valid && (!bus.instr_valid || bus.instr_ready);
    // A returning fetch that cannot be loaded is dropped and refetched later.
    replay    = run && s2.valid && !load;
    hlt_load  = load && (bus.instr_in[IW-1 -: OPW] == OPW'(HLT_OP));
    flush     = start_run || (run && (bus.jump_en || replay || hlt_load));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (hlt_load)  state_nxt = HALT;
      HALT:    if (bus.start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.wr_pc       = run;
    bus.busy        = run;
    bus.address_bus = fetch_addr;
  end

  // fetch_addr is frozen on the HLT edge so address_bus keeps showing the
  // last issued address while stopped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_addr <= '0;
    end else if (start_run) begin
      fetch_addr <= '0;
    end else if (run && !hlt_load) begin
      if (bus.jump_en)  fetch_addr <= bus.jump_addr;
      else if (replay)  fetch_addr <= AB'(s2.addr);
      else              fetch_addr <= fetch_addr + AB'(1);
    end
  end

  // Output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.instr_out   <= '0;
      bus.instr_pc    <= '0;
      bus.instr_valid <= 1'b0;
      bus.halted      <= 1'b0;
    end else if (start_run) begin
      bus.instr_out   <= '0;
      bus.instr_pc    <= '0;
      bus.instr_valid <= 1'b0;
      bus.halted      <= 1'b0;
    end else if (load) begin
      bus.instr_out   <= bus.instr_in;
      bus.instr_pc    <= AB'(s2.addr);
      bus.instr_valid <= 1'b1;
      if (hlt_load) bus.halted <= 1'b1;
    end else if (bus.instr_ready) begin
      bus.instr_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
module tb_pc_fetch_sequencer;
  import bip_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pc_fetch_sequencer_if #(.AB(11), .IW(16)) bus ();

  pc_fetch_sequencer #(.AB(11), .IW(16), .OPW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_issue;
  logic [10:0] exp_q[$];
  int acc_cyc[$];

  // Program Counter register + synchronous program memory model
  logic [15:0] mem [0:2047];
  logic [10:0] pc_q;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.wr_pc) pc_q <= bus.address_bus;
    bus.instr_in <= mem[pc_q];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted instruction must be the next expected one.
  always @(negedge clk) begin
    if (rst_n && bus.instr_valid && bus.instr_ready) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected: observed pc 0x%0h expected none", bus.instr_pc);
      end
      if (exp_q.size() != 0) begin : pop
        logic [10:0] e;
        e = exp_q.pop_front();
        check("sb_pc", 32'(bus.instr_pc), 32'(e));
        check("sb_instr", 32'(bus.instr_out), 32'(mem[e]));
        acc_cyc.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 2048; i++) mem[i] = {5'd1, 11'(i)};
  endtask

  task automatic push_seq(input logic [10:0] first, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(first + 11'(i));
  endtask

  task automatic start_pulse();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic jump_pulse(input logic [10:0] target);
    bus.jump_en   = 1'b1;
    bus.jump_addr = target;
    tick();
    bus.jump_en   = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_pc"},       32'(bus.wr_pc), 0);
    check({tag, "_address_bus"}, 32'(bus.address_bus), 0);
    check({tag, "_instr_out"},   32'(bus.instr_out), 0);
    check({tag, "_instr_pc"},    32'(bus.instr_pc), 0);
    check({tag, "_instr_valid"}, 32'(bus.instr_valid), 0);
    check({tag, "_halted"},      32'(bus.halted), 0);
    check({tag, "_busy"},        32'(bus.busy), 0);
  endtask

  task automatic wait_halted(input string tag);
    for (int i = 0; i < 80 && !bus.halted; i++) tick();
    check({tag, "_halted"}, 32'(bus.halted), 1);
    tick();
    tick();
    check({tag, "_drained"}, 32'(exp_q.size()), 0);
    check({tag, "_no_wr_pc"}, 32'(bus.wr_pc), 0);
    check({tag, "_hlt_accepted"}, 32'(bus.instr_valid), 0);
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.jump_en     = 1'b0;
    bus.jump_addr   = '0;
    bus.instr_ready = 1'b0;
    fill_mem();
    #2;
    check_reset_outputs("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Sequential fetch: ADD, LD, ST, HLT
    fill_mem();
    mem[1] = {5'd2, 11'd1};
    mem[2] = {5'd3, 11'd2};
    mem[3] = {HLT_OP, 11'd3};
    bus.instr_ready = 1'b1;
    acc_cyc.delete();
    push_seq(11'd0, 4);
    start_pulse();
    for (int i = 0; i < 10 && !bus.wr_pc; i++) tick();
    t_issue = cyc;
    check("seq_first_addr", 32'(bus.address_bus), 0);
    for (int i = 0; i < 10 && !bus.instr_valid; i++) tick();
    check("seq_latency", 32'(cyc - t_issue), 3);
    wait_halted("seq");
    check("seq_accepts", 32'(acc_cyc.size()), 4);
    if (acc_cyc.size() == 4) check("seq_consecutive", 32'(acc_cyc[3] - acc_cyc[0]), 3);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("seq_halt_wr_pc", 32'(bus.wr_pc), 0);
    end
    check("seq_halt_busy", 32'(bus.busy), 0);

    // Stall replay while instr_pc = 1
    fill_mem();
    mem[4] = {HLT_OP, 11'd4};
    push_seq(11'd0, 5);
    start_pulse();
    check("restart_halted", 32'(bus.halted), 0);
    check("restart_busy", 32'(bus.busy), 1);
    for (int i = 0; i < 20 && !(bus.instr_valid && bus.instr_pc == 11'd1); i++) tick();
    check("stall_reach_pc1", 32'(bus.instr_pc), 1);
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_hold_pc", 32'(bus.instr_pc), 1);
      check("stall_hold_out", 32'(bus.instr_out), 32'(mem[1]));
      check("stall_hold_valid", 32'(bus.instr_valid), 1);
    end
    bus.instr_ready = 1'b1;
    wait_halted("stall");

    // Jump to 0x400 while fetch_addr = 5: 4 and 5 must never appear
    fill_mem();
    mem[11'h401] = {HLT_OP, 11'h401};
    push_seq(11'd0, 4);
    push_seq(11'h400, 2);
    start_pulse();
    for (int i = 0; i < 20 && !(bus.wr_pc && bus.address_bus == 11'd5); i++) tick();
    check("jump_reach_5", 32'(bus.address_bus), 5);
    jump_pulse(11'h400);
    check("jump_target", 32'(bus.address_bus), 32'h400);
    check("jump_current_pc", 32'(bus.instr_pc), 3);
    wait_halted("jump");

    // Wrap-around 0x7FE -> 0x7FF -> 0x000
    fill_mem();
    mem[2] = {HLT_OP, 11'd2};
    push_seq(11'h7FE, 5);
    start_pulse();
    for (int i = 0; i < 10 && !(bus.wr_pc && bus.address_bus == 11'd1); i++) tick();
    jump_pulse(11'h7FE);
    check("wrap_addr0", 32'(bus.address_bus), 32'h7FE);
    tick();
    check("wrap_addr1", 32'(bus.address_bus), 32'h7FF);
    tick();
    check("wrap_addr2", 32'(bus.address_bus), 0);
    wait_halted("wrap");

    // Jump on the same cycle as a replay
    fill_mem();
    mem[11'h124] = {HLT_OP, 11'h124};
    exp_q.push_back(11'd0);
    push_seq(11'h123, 2);
    bus.instr_ready = 1'b0;
    start_pulse();
    for (int i = 0; i < 10 && !bus.instr_valid; i++) tick();
    check("coll_first_valid", 32'(bus.instr_valid), 1);
    jump_pulse(11'h123);
    check("coll_fetch_addr", 32'(bus.address_bus), 32'h123);
    check("coll_hold_pc", 32'(bus.instr_pc), 0);
    check("coll_hold_valid", 32'(bus.instr_valid), 1);
    bus.instr_ready = 1'b1;
    wait_halted("coll");

    // Asynchronous reset mid-run, then restart
    fill_mem();
    push_seq(11'd0, 20);
    start_pulse();
    for (int i = 0; i < 6; i++) tick();
    check("rst_pre_busy", 32'(bus.busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_idle_wr_pc", 32'(bus.wr_pc), 0);
    mem[1] = {HLT_OP, 11'd1};
    push_seq(11'd0, 2);
    start_pulse();
    wait_halted("post_rst");
    push_seq(11'd0, 2);
    start_pulse();
    check("halt_restart_halted", 32'(bus.halted), 0);
    check("halt_restart_addr", 32'(bus.address_bus), 0);
    wait_halted("halt_restart");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
